// File: rtl/uinst_encode_writer.sv
// uinst_encode_writer: packs one-hot op class / ALU funct / M source / functional
// destination selects into a 49-bit microinstruction, validates them, and writes
// the word into control memory with a strobe held for WRITE_CYCLES cycles.
// Optional feature macro: UINST_ENCODE_WRITER_AUTOINC_EN adds req_next and a
// last-written-address register so consecutive writes can auto-increment.
`timescale 1ns/1ps
module uinst_encode_writer #(
    parameter int ADDR_W       = 14,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [48:0]       req_base,
    input  logic [3:0]        req_class,
    input  logic [3:0]        req_funct,
    input  logic [12:0]       req_src,
    input  logic [11:0]       req_dst,
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
    input  logic              req_next,
`endif
    output logic [ADDR_W-1:0] cram_addr,
    output logic [48:0]       cram_data,
    output logic              cram_we,
    output logic              iwrited,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, DONE} state_t;

    localparam logic [3:0] WC_LAST = 4'(WRITE_CYCLES - 1);

    state_t      state, state_d;
    logic [3:0]  wcnt;
    logic [48:0] base_q;
    logic [3:0]  class_q, funct_q;
    logic [12:0] src_q;
    logic [11:0] dst_q;
    logic [1:0]  code_q;
    logic        err_q;
    logic [48:0] word;
    logic [1:0]  chk_code;
    logic [1:0]  cls_idx, fn_idx;
    logic [2:0]  src_lo_idx, src_hi_idx, pdl_idx;

`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
    logic [ADDR_W-1:0] last_addr;
`endif

    // Bit position of a one-hot 4-bit select (0 when the select is empty).
    function automatic logic [1:0] oh_idx4(input logic [3:0] v);
        oh_idx4 = 2'd0;
        for (int i = 0; i < 4; i++)
            if (v[i]) oh_idx4 = 2'(i);
    endfunction

    // Bit position of a one-hot 8-bit select (0 when the select is empty).
    function automatic logic [2:0] oh_idx8(input logic [7:0] v);
        oh_idx8 = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) oh_idx8 = 3'(i);
    endfunction

    // True when more than one bit is set.
    function automatic logic multi_hot(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

    // Encode the registered selects into the base word and classify errors.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        word       = base_q;
        chk_code   = 2'd0;
        cls_idx    = oh_idx4(class_q);
        fn_idx     = oh_idx4(funct_q);
        src_lo_idx = oh_idx8(src_q[7:0]);
        src_hi_idx = oh_idx8({3'b000, src_q[12:8]});
        pdl_idx    = oh_idx8(dst_q[9:2]);

        word[44:43] = cls_idx;
        if (funct_q != 4'd0)
            word[11:10] = fn_idx;

        if (src_q != 13'd0) begin
            word[31] = 1'b1;
            if (src_q[7:0] != 8'd0) begin
                word[29]    = 1'b0;
                word[28:26] = src_lo_idx;
            end else begin
                word[29]    = 1'b1;
                word[28:26] = src_hi_idx;
            end
        end

        if (dst_q != 12'd0) begin
            word[25] = 1'b0;
            if (dst_q[11]) begin
                word[23:22] = 2'b11;
            end else if (dst_q[10]) begin
                word[23:22] = 2'b10;
            end else if (dst_q[1]) begin
                word[23:22] = 2'b00;
                word[21:19] = 3'b010;
            end else if (dst_q[0]) begin
                word[23:22] = 2'b00;
                word[21:19] = 3'b001;
            end else begin
                word[23:22] = 2'b01;
                word[21:19] = pdl_idx;
            end
        end

        if (class_q == 4'd0)
            chk_code = 2'd3;
        else if (multi_hot({12'd0, class_q}) || multi_hot({12'd0, funct_q}) ||
                 multi_hot({3'd0, src_q})    || multi_hot({4'd0, dst_q}))
            chk_code = 2'd1;
        else if (dst_q != 12'd0 && (class_q[1] || class_q[2]))
            chk_code = 2'd2;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state;
        req_ready = (state == IDLE);
        cram_we   = (state == WRITE);
        iwrited   = (state == WRITE);
        done      = (state == DONE) && !err_q;
        err       = (state == DONE) && err_q;
        err_code  = err ? code_q : 2'd0;
        case (state)
            IDLE:    if (req_valid) state_d = CHECK;
            CHECK:   state_d = (chk_code != 2'd0) ? DONE : WRITE;
            WRITE:   if (wcnt == WC_LAST) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Request capture, encoded-word register and write-cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the datapath is reset too, so cram_data falls to 0 the moment
        // reset asserts, even in the middle of a write.
        if (!reset_n) begin
            base_q    <= '0;
            class_q   <= '0;
            funct_q   <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            code_q    <= '0;
            err_q     <= 1'b0;
            wcnt      <= '0;
            cram_addr <= '0;
            cram_data <= '0;
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
            last_addr <= '0;
`endif
        end else begin
            wcnt <= (state == WRITE) ? wcnt + 4'd1 : 4'd0;
            case (state)
                IDLE: if (req_valid) begin
                    base_q  <= req_base;
                    class_q <= req_class;
                    funct_q <= req_funct;
                    src_q   <= req_src;
                    dst_q   <= req_dst;
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
                    cram_addr <= req_next ? last_addr + ADDR_W'(1) : req_addr;
`else
                    cram_addr <= req_addr;
`endif
                end
                CHECK: begin
                    code_q <= chk_code;
                    err_q  <= (chk_code != 2'd0);
                    if (chk_code == 2'd0) cram_data <= word;
                end
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
                WRITE: if (wcnt == WC_LAST) last_addr <= cram_addr;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uinst_encode_writer.sv
// Self-checking bench for uinst_encode_writer: directed cases plus randomized
// requests compared against a field-level reference encoder. Define
// UINST_ENCODE_WRITER_AUTOINC_EN to also exercise the auto-increment address.
`timescale 1ns/1ps
module tb_uinst_encode_writer;

    localparam int ADDR_W = 14;
    localparam int WC     = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [48:0]       req_base = '0;
    logic [3:0]        req_class = '0;
    logic [3:0]        req_funct = '0;
    logic [12:0]       req_src = '0;
    logic [11:0]       req_dst = '0;
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
    logic              req_next = 1'b0;
`endif
    logic [ADDR_W-1:0] cram_addr;
    logic [48:0]       cram_data;
    logic              cram_we, iwrited, done, err;
    logic [1:0]        err_code;

    int tests_run = 0;
    int tests_failed = 0;

    // Observations from the most recent request.
    int                obs_we_first, obs_we_count, obs_done, obs_done_count, obs_err, obs_ready;
    logic [1:0]        obs_code;
    logic [48:0]       obs_data;
    logic [ADDR_W-1:0] obs_addr;
    bit                obs_stable, obs_iw_ok;
    logic [ADDR_W-1:0] tb_last = '0;

    uinst_encode_writer #(.ADDR_W(ADDR_W), .WRITE_CYCLES(WC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_base(req_base),
        .req_class(req_class), .req_funct(req_funct),
        .req_src(req_src), .req_dst(req_dst),
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
        .req_next(req_next),
`endif
        .cram_addr(cram_addr), .cram_data(cram_data), .cram_we(cram_we),
        .iwrited(iwrited), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Replace a bit field of a word.
    function automatic longint unsigned put(input longint unsigned w, input int lsb,
                                            input int width, input longint unsigned val);
        longint unsigned mask;
        mask = ((64'd1 << width) - 64'd1) << lsb;
        return (w & ~mask) | ((val << lsb) & mask);
    endfunction

    // Reference encoder: error code by priority, then field substitution.
    task automatic model(input logic [48:0] base, input logic [3:0] cls, input logic [3:0] fn,
                         input logic [12:0] src, input logic [11:0] dst,
                         output logic [1:0] code, output logic [48:0] word);
        longint unsigned w;
        int k, j;
        code = 2'd0;
        if (cls == 4'd0) code = 2'd3;
        else if ($countones(cls) > 1 || $countones(fn) > 1 ||
                 $countones(src) > 1 || $countones(dst) > 1) code = 2'd1;
        else if (dst != 12'd0 && (cls == 4'b0010 || cls == 4'b0100)) code = 2'd2;
        w = 64'(base);
        w = put(w, 43, 2, 64'($clog2(cls)));
        if (fn != 4'd0) w = put(w, 10, 2, 64'($clog2(fn)));
        if (src != 13'd0) begin
            k = $clog2(src);
            w = put(w, 31, 1, 1);
            w = put(w, 29, 1, (k >= 8) ? 1 : 0);
            w = put(w, 26, 3, 64'((k >= 8) ? k - 8 : k));
        end
        if (dst != 12'd0) begin
            j = $clog2(dst);
            w = put(w, 25, 1, 0);
            if (j == 11)      w = put(w, 22, 2, 3);
            else if (j == 10) w = put(w, 22, 2, 2);
            else if (j <= 1)  w = put(put(w, 22, 2, 0), 19, 3, 64'(j + 1));
            else              w = put(put(w, 22, 2, 1), 19, 3, 64'(j - 2));
        end
        word = w[48:0];
    endtask

    // Issue one request from a negedge with the DUT idle, then watch it for a
    // bounded number of cycles (cycle 1 = the cycle after the accepting edge).
    task automatic run_req(input logic [ADDR_W-1:0] addr, input logic [48:0] base,
                           input logic [3:0] cls, input logic [3:0] fn,
                           input logic [12:0] src, input logic [11:0] dst, input logic nxt);
        obs_we_first = -1; obs_we_count = 0; obs_done = -1; obs_done_count = 0;
        obs_err = -1; obs_ready = -1; obs_code = 2'd0; obs_data = '0; obs_addr = '0;
        obs_stable = 1'b1; obs_iw_ok = 1'b1;
        req_addr = addr; req_base = base; req_class = cls; req_funct = fn;
        req_src = src; req_dst = dst; req_valid = 1'b1;
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
        req_next = nxt;
`else
        if (nxt) $display("[TB] note: req_next has no effect in this build");
`endif
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (cram_we) begin
                if (obs_we_first < 0) begin
                    obs_we_first = c; obs_data = cram_data; obs_addr = cram_addr;
                end else if (cram_data !== obs_data || cram_addr !== obs_addr) begin
                    obs_stable = 1'b0;
                end
                obs_we_count++;
            end
            if (iwrited !== cram_we) obs_iw_ok = 1'b0;
            if (done) begin obs_done = c; obs_done_count++; end
            if (err) begin obs_err = c; obs_code = err_code; end
            if (req_ready && (obs_done >= 0 || obs_err >= 0)) begin
                obs_ready = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({req_ready, cram_we, iwrited, done, err, err_code, cram_addr, cram_data} !== {1'b1, 69'd0}) begin
            tests_failed++;
            $display("FAIL reset_during: ready=%b we=%b iw=%b done=%b err=%b code=%0d addr=%h data=%h, need ready=1 rest 0",
                     req_ready, cram_we, iwrited, done, err, err_code, cram_addr, cram_data);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({req_ready, cram_we, done, err} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_after: ready=%b we=%b done=%b err=%b, need 1000", req_ready, cram_we, done, err);
        end
    endtask

    task automatic test_alu_vma();
        run_req(14'h0123, 49'd0, 4'b0001, 4'b0100, 13'h0080, 12'h400, 1'b0);
        tests_run++;
        if (obs_data !== 49'h0_9C80_0800 || obs_addr !== 14'h0123) begin
            tests_failed++;
            $display("FAIL alu_vma_word: data=%h addr=%h, need 09c800800 @0123", obs_data, obs_addr);
        end
        tests_run++;
        if (obs_we_first !== 2 || obs_we_count !== WC || obs_done !== 2 + WC || obs_done_count !== 1 ||
            obs_ready !== 3 + WC || obs_err !== -1 || !obs_stable || !obs_iw_ok) begin
            tests_failed++;
            $display("FAIL alu_vma_timing: we_first=%0d we_n=%0d done=%0d/%0d ready=%0d err=%0d stable=%b iw=%b, need 2 %0d %0d/1 %0d -1 1 1",
                     obs_we_first, obs_we_count, obs_done, obs_done_count, obs_ready, obs_err,
                     obs_stable, obs_iw_ok, WC, 2 + WC, 3 + WC);
        end
        tb_last = 14'h0123;
    endtask

    task automatic test_pdl_allones();
        run_req(14'h2AAA, {49{1'b1}}, 4'b1000, 4'd0, 13'd0, 12'h008, 1'b0);
        tests_run++;
        if (obs_data !== 49'h1_FFFF_FD4F_FFFF || obs_err !== -1 || obs_done !== 2 + WC) begin
            tests_failed++;
            $display("FAIL pdl_allones: data=%h err=%0d done=%0d, need 1fffffd4fffff -1 %0d",
                     obs_data, obs_err, obs_done, 2 + WC);
        end
        tb_last = 14'h2AAA;
    endtask

    task automatic test_err_dest_jump();
        run_req(14'h0042, 49'd0, 4'b0010, 4'd0, 13'd0, 12'h001, 1'b0);
        tests_run++;
        if (obs_err !== 2 || obs_code !== 2'd2) begin
            tests_failed++;
            $display("FAIL jump_dest_err: err_cycle=%0d code=%0d, need 2 / 2", obs_err, obs_code);
        end
        tests_run++;
        if (obs_we_count !== 0 || obs_done_count !== 0 || obs_ready !== 3) begin
            tests_failed++;
            $display("FAIL jump_dest_side: we_n=%0d done_n=%0d ready=%0d, need 0 0 3",
                     obs_we_count, obs_done_count, obs_ready);
        end
    endtask

    task automatic test_err_codes();
        logic [3:0]  cls_t [4] = '{4'b0001, 4'b0000, 4'b0100, 4'b0011};
        logic [12:0] src_t [4] = '{13'h0003, 13'h0003, 13'h0000, 13'h0001};
        logic [11:0] dst_t [4] = '{12'h000, 12'h000, 12'h800, 12'h000};
        logic [1:0]  exp_t [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 4; i++) begin
            run_req(14'(i), 49'h1234_5678_9ABC, cls_t[i], 4'd0, src_t[i], dst_t[i], 1'b0);
            tests_run++;
            if (obs_err !== 2 || obs_code !== exp_t[i] || obs_we_count !== 0 || obs_ready !== 3) begin
                tests_failed++;
                $display("FAIL err_code_%0d: err_cycle=%0d code=%0d we_n=%0d ready=%0d, need 2 %0d 0 3",
                         i, obs_err, obs_code, obs_we_count, obs_ready, exp_t[i]);
            end
        end
    endtask

    // Random one-hot-ish select: mostly one bit, sometimes empty, sometimes arbitrary.
    function automatic logic [15:0] rand_sel(input int n);
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 16'd0;
        if (r < 9) return 16'd1 << $urandom_range(0, n - 1);
        return 16'($urandom_range(0, (1 << n) - 1));
    endfunction

    task automatic test_random();
        logic [63:0] r64;
        logic [15:0] s;
        logic [3:0]  cls, fn;
        logic [12:0] src;
        logic [11:0] dst;
        logic [ADDR_W-1:0] addr;
        logic [1:0]  exp_code;
        logic [48:0] exp_word;
        for (int it = 0; it < 60; it++) begin
            r64 = {$urandom(), $urandom()};
            s = (($urandom() % 10) == 0) ? 16'($urandom_range(0, 15)) : 16'd1 << $urandom_range(0, 3);
            cls = s[3:0];
            s = rand_sel(4);  fn  = s[3:0];
            s = rand_sel(13); src = s[12:0];
            s = rand_sel(12); dst = s[11:0];
            addr = 14'($urandom());
            model(r64[48:0], cls, fn, src, dst, exp_code, exp_word);
            run_req(addr, r64[48:0], cls, fn, src, dst, 1'b0);
            tests_run++;
            if (exp_code != 2'd0) begin
                if (obs_err !== 2 || obs_code !== exp_code || obs_we_count !== 0 ||
                    obs_done_count !== 0 || obs_ready !== 3) begin
                    tests_failed++;
                    $display("FAIL rand_err_%0d: err_cycle=%0d code=%0d we_n=%0d done_n=%0d ready=%0d, need 2 %0d 0 0 3",
                             it, obs_err, obs_code, obs_we_count, obs_done_count, obs_ready, exp_code);
                end
            end else begin
                if (obs_data !== exp_word || obs_addr !== addr || obs_err !== -1 ||
                    obs_we_first !== 2 || obs_we_count !== WC || obs_done !== 2 + WC ||
                    obs_ready !== 3 + WC || !obs_stable || !obs_iw_ok) begin
                    tests_failed++;
                    $display("FAIL rand_write_%0d: data=%h addr=%h err=%0d we=%0d/%0d done=%0d ready=%0d, need %h %h -1 2/%0d %0d %0d",
                             it, obs_data, obs_addr, obs_err, obs_we_first, obs_we_count, obs_done,
                             obs_ready, exp_word, addr, WC, 2 + WC, 3 + WC);
                end
                tb_last = addr;
            end
        end
    endtask

    // req_valid held high: a new request is accepted every 3+WC cycles.
    task automatic test_back_to_back();
        int n_done, n_we;
        n_done = 0; n_we = 0;
        req_addr = 14'h0300; req_base = 49'd0; req_class = 4'b0001; req_funct = 4'd0;
        req_src = 13'd0; req_dst = 12'd0; req_valid = 1'b1;
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
        req_next = 1'b0;
`endif
        for (int c = 1; c <= 3 * (3 + WC); c++) begin
            @(negedge clk);
            if (done) n_done++;
            if (cram_we) n_we++;
        end
        req_valid = 1'b0;
        tests_run++;
        if (n_done !== 3 || n_we !== 3 * WC) begin
            tests_failed++;
            $display("FAIL back_to_back: done_n=%0d we_n=%0d, need 3 %0d", n_done, n_we, 3 * WC);
        end
        tb_last = 14'h0300;
    endtask

    task automatic test_reset_mid_write();
        bit saw_done;
        saw_done = 1'b0;
        req_addr = 14'h0777; req_base = 49'h0_FFFF_0000; req_class = 4'b0001; req_funct = 4'b0001;
        req_src = 13'd0; req_dst = 12'd0; req_valid = 1'b1;
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
        req_next = 1'b0;
`endif
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (cram_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL midwrite_pre: cram_we=%b, need 1", cram_we);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({cram_we, iwrited, cram_data} !== 51'd0) begin
            tests_failed++;
            $display("FAIL midwrite_drop: we=%b iw=%b data=%h, need 0 0 0", cram_we, iwrited, cram_data);
        end
        repeat (2) begin @(negedge clk); if (done) saw_done = 1'b1; end
        reset_n = 1'b1;
        repeat (4) begin @(negedge clk); if (done) saw_done = 1'b1; end
        tests_run++;
        if (req_ready !== 1'b1 || saw_done) begin
            tests_failed++;
            $display("FAIL midwrite_after: ready=%b saw_done=%b, need 1 0", req_ready, saw_done);
        end
        tb_last = '0;
    endtask

`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
    task automatic test_autoinc();
        logic [ADDR_W-1:0] exp_addr;
        run_req(14'h3FFF, 49'd5, 4'b0001, 4'd0, 13'd0, 12'd0, 1'b0);
        tests_run++;
        if (obs_addr !== 14'h3FFF || obs_done !== 2 + WC) begin
            tests_failed++;
            $display("FAIL autoinc_base: addr=%h done=%0d, need 3fff %0d", obs_addr, obs_done, 2 + WC);
        end
        tb_last = 14'h3FFF;
        exp_addr = tb_last + 14'd1;
        run_req(14'h0555, 49'd6, 4'b0001, 4'd0, 13'd0, 12'd0, 1'b1);
        tests_run++;
        if (obs_addr !== exp_addr || obs_done !== 2 + WC) begin
            tests_failed++;
            $display("FAIL autoinc_wrap: addr=%h done=%0d, need %h %0d", obs_addr, obs_done, exp_addr, 2 + WC);
        end
        tb_last = exp_addr;
        run_req(14'h0999, 49'd7, 4'b0000, 4'd0, 13'd0, 12'd0, 1'b1);
        exp_addr = tb_last + 14'd1;
        run_req(14'h0666, 49'd8, 4'b0001, 4'd0, 13'd0, 12'd0, 1'b1);
        tests_run++;
        if (obs_addr !== exp_addr || obs_done !== 2 + WC) begin
            tests_failed++;
            $display("FAIL autoinc_after_err: addr=%h done=%0d, need %h %0d", obs_addr, obs_done, exp_addr, 2 + WC);
        end
        tb_last = exp_addr;
    endtask
`endif

    initial begin
        test_reset();
        test_alu_vma();
        test_pdl_allones();
        test_err_dest_jump();
        test_err_codes();
        test_random();
        test_back_to_back();
        test_reset_mid_write();
`ifdef UINST_ENCODE_WRITER_AUTOINC_EN
        test_autoinc();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
